// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues program-memory reads on command from the
// microcode sequencer, latches IR/operand, and maintains the program counter.
module instr_fetch_unit #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] PROG_LAST = 8'hFF,
    parameter int                TIMEOUT   = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        mcontrol,
    input  logic              PCD,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic [3:0]        IR_Out,
    output logic [3:0]        IR_Arg,
    output logic [7:0]        operand,
    output logic              busy,
    output logic              done,
    output logic              y,
    output logic              err
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_INSTR = 2'b01;
    localparam logic [1:0] CMD_OPND  = 2'b10;
    localparam logic [1:0] CMD_JUMP  = 2'b11;

    // Counter holds 0..TIMEOUT-1; the last value is the final WAIT cycle.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]        state_reg;
    logic [2:0]        state_next;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              cmd_opnd_reg;
    logic [7:0]        ir_reg;
    logic [7:0]        operand_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic              y_reg;
    logic              err_reg;

    logic fetch_accept;
    logic jump_accept;
    logic timeout_hit;

    assign fetch_accept = (state_reg == ST_IDLE) &&
                          ((mcontrol == CMD_INSTR) || (mcontrol == CMD_OPND));
    assign jump_accept  = (state_reg == ST_IDLE) && (mcontrol == CMD_JUMP);
    assign timeout_hit  = (wait_cnt_reg == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (jump_accept) begin
                    state_next = ST_DONE;
                end else if (fetch_accept) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ:  state_next = ST_WAIT;
            ST_WAIT: begin
                if (mem_ack || timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_HOLD;
            ST_HOLD: begin
                // Waiting for the sequencer to drop the command makes a
                // level-held command execute exactly once.
                if (mcontrol == CMD_IDLE) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= '0;
            mem_addr_reg <= '0;
            cmd_opnd_reg <= 1'b0;
            ir_reg       <= 8'h00;
            operand_reg  <= 8'h00;
            wait_cnt_reg <= '0;
            y_reg        <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;

            case (state_reg)
                ST_IDLE: begin
                    if (fetch_accept) begin
                        cmd_opnd_reg <= (mcontrol == CMD_OPND);
                        mem_addr_reg <= pc_reg;
                    end
                end
                ST_REQ: begin
                    wait_cnt_reg <= '0;
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        if (cmd_opnd_reg) begin
                            operand_reg <= mem_rdata;
                        end else begin
                            ir_reg <= mem_rdata;
                        end
                    end else if (timeout_hit) begin
                        err_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase

            // An accepted jump overrides a coincident increment strobe.
            if (jump_accept) begin
                pc_reg <= ADDR_W'(operand_reg);
            end else if (PCD) begin
                pc_reg <= pc_reg + 1'b1;
            end

            if (PCD && (pc_reg == PROG_LAST)) begin
                y_reg <= 1'b1;
            end
        end
    end

    assign mem_addr = mem_addr_reg;
    assign mem_rd   = (state_reg == ST_REQ) || (state_reg == ST_WAIT);
    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_DONE);
    assign IR_Out   = ir_reg[7:4];
    assign IR_Arg   = ir_reg[3:0];
    assign operand  = operand_reg;
    assign y        = y_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a table of fetch/jump vectors run
// through a scoreboard, plus held-command and reset-mid-WAIT sequences.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mcontrol;
    logic       PCD;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic [3:0] IR_Out;
    logic [3:0] IR_Arg;
    logic [7:0] operand;
    logic       busy;
    logic       done;
    logic       y;
    logic       err;

    logic [7:0] mem_model [256];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [1:0] cmd;
        int         ack_wait;   // WAIT cycle (1-based) carrying mem_ack, 0 = never
        int         pcd_before; // PCD pulses issued in IDLE before the command
        bit         pcd_cmd;    // PCD in the command cycle itself
        bit         pcd_wait;   // PCD in the first WAIT cycle
        logic [7:0] exp_addr;
        logic [7:0] exp_ir;
        logic [7:0] exp_op;
        int         exp_rd;     // cycles with mem_rd high
        bit         exp_err;
        bit         exp_y;
    } vec_t;

    vec_t vecs [11];
    vec_t sb [$];

    instr_fetch_unit #(
        .ADDR_W   (8),
        .PROG_LAST(8'hFF),
        .TIMEOUT  (15)
    ) dut (
        .clock    (clk),
        .reset    (reset),
        .mcontrol (mcontrol),
        .PCD      (PCD),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .IR_Out   (IR_Out),
        .IR_Arg   (IR_Arg),
        .operand  (operand),
        .busy     (busy),
        .done     (done),
        .y        (y),
        .err      (err)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_model[mem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pcd_pulse();
        PCD = 1'b1;
        tick();
        PCD = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        vec_t       e;
        int         cyc;
        int         rd_cnt;
        logic [7:0] addr0;
        bit         unstable;
        bit         got;
        for (int p = 0; p < v.pcd_before; p++) pcd_pulse();
        sb.push_back(v);
        mcontrol = v.cmd;
        PCD      = v.pcd_cmd;
        cyc = 0; rd_cnt = 0; addr0 = 8'h00; unstable = 0; got = 0;
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            mcontrol = 2'b00;
            PCD      = 1'b0;
            if (mem_rd) begin
                rd_cnt++;
                if (rd_cnt == 1) addr0 = mem_addr;
                else if (mem_addr !== addr0) unstable = 1;
            end
            PCD     = v.pcd_wait && mem_rd && (rd_cnt == 2);
            mem_ack = (v.ack_wait > 0) && mem_rd && (rd_cnt == v.ack_wait + 1);
            if (done) got = 1;
        end
        mem_ack = 1'b0;
        PCD     = 1'b0;
        e = sb.pop_front();
        if (!got) begin
            chk($sformatf("v%0d_done_seen", idx), 0, 1);
        end else begin
            chk($sformatf("v%0d_ir", idx), {IR_Out, IR_Arg}, e.exp_ir);
            chk($sformatf("v%0d_operand", idx), operand, e.exp_op);
            chk($sformatf("v%0d_err", idx), err, e.exp_err);
            chk($sformatf("v%0d_y", idx), y, e.exp_y);
            chk($sformatf("v%0d_rd_cycles", idx), rd_cnt, e.exp_rd);
            chk($sformatf("v%0d_latency", idx), cyc, e.exp_rd + 1);
            if (e.exp_rd > 0) begin
                chk($sformatf("v%0d_addr", idx), addr0, e.exp_addr);
                chk($sformatf("v%0d_addr_stable", idx), unstable, 0);
            end
        end
        $display("vec %0d: cmd=%b addr=%02h rd=%0d lat=%0d IR=%h%h op=%02h err=%b y=%b",
                 idx, v.cmd, addr0, rd_cnt, cyc, IR_Out, IR_Arg, operand, err, y);
        tick();
        chk($sformatf("v%0d_done_pulse", idx), done, 0);
        tick();
        chk($sformatf("v%0d_idle", idx), busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int   bursts;
        int   dones;
        int   run;
        bit   prev_rd;
        bit   seen;
        logic [7:0] addr_seen;
        vec_t last_v;

        for (int i = 0; i < 256; i++) mem_model[i] = 8'(8'h4A + i);
        mem_model[8'h03] = 8'h20;
        mem_model[8'h21] = 8'hFF;

        //            cmd    ack pb pc pw  addr   ir     op     rd err y
        vecs[0]  = '{2'b01, 2, 0, 0, 0, 8'h00, 8'h4A, 8'h00, 3,  0, 0};
        vecs[1]  = '{2'b01, 1, 1, 0, 0, 8'h01, 8'h4B, 8'h00, 2,  0, 0};
        vecs[2]  = '{2'b10, 3, 2, 0, 0, 8'h03, 8'h4B, 8'h20, 4,  0, 0};
        vecs[3]  = '{2'b01, 1, 0, 0, 1, 8'h03, 8'h20, 8'h20, 2,  0, 0};
        vecs[4]  = '{2'b01, 1, 0, 0, 0, 8'h04, 8'h4E, 8'h20, 2,  0, 0};
        vecs[5]  = '{2'b11, 0, 0, 1, 0, 8'h00, 8'h4E, 8'h20, 0,  0, 0};
        vecs[6]  = '{2'b01, 1, 0, 0, 0, 8'h20, 8'h6A, 8'h20, 2,  0, 0};
        vecs[7]  = '{2'b10, 0, 0, 0, 0, 8'h20, 8'h6A, 8'h20, 16, 1, 0};
        vecs[8]  = '{2'b10, 1, 1, 0, 0, 8'h21, 8'h6A, 8'hFF, 2,  1, 0};
        vecs[9]  = '{2'b11, 0, 0, 0, 0, 8'h00, 8'h6A, 8'hFF, 0,  1, 0};
        vecs[10] = '{2'b01, 2, 1, 0, 0, 8'h00, 8'h4A, 8'hFF, 3,  1, 1};

        reset = 1'b1; mcontrol = 2'b00; PCD = 1'b0; mem_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_ir", {IR_Out, IR_Arg}, 8'h00);
        chk("rst_operand", operand, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_y", y, 0);
        chk("rst_err", err, 0);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Level-held fetch command executes once.
        pcd_pulse();
        mcontrol = 2'b01;
        bursts = 0; dones = 0; run = 0; prev_rd = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mem_rd && !prev_rd) bursts++;
            run = mem_rd ? run + 1 : 0;
            prev_rd = mem_rd;
            mem_ack = mem_rd && (run == 2);
            if (done) dones++;
        end
        mem_ack = 1'b0;
        chk("held_bursts", bursts, 1);
        chk("held_dones", dones, 1);
        chk("held_busy", busy, 1);
        chk("held_ir", {IR_Out, IR_Arg}, 8'h4B);
        $display("held: bursts=%0d dones=%0d IR=%h%h", bursts, dones, IR_Out, IR_Arg);
        mcontrol = 2'b00;
        tick();
        chk("held_release_idle", busy, 0);
        mcontrol = 2'b01;
        seen = 0; addr_seen = 8'h00; run = 0; dones = 0;
        for (int c = 0; c < 10 && dones == 0; c++) begin
            tick();
            mcontrol = 2'b00;
            if (mem_rd && !seen) begin seen = 1; addr_seen = mem_addr; end
            run = mem_rd ? run + 1 : 0;
            mem_ack = mem_rd && (run == 2);
            if (done) dones++;
        end
        mem_ack = 1'b0;
        chk("refetch_started", seen, 1);
        chk("refetch_addr", addr_seen, 8'h01);
        chk("refetch_done", dones, 1);
        $display("refetch: addr=%02h done=%0d", addr_seen, dones);
        tick(); tick();

        // Reset in the middle of WAIT, followed by a late acknowledge.
        pcd_pulse();
        mcontrol = 2'b01;
        tick();
        mcontrol = 2'b00;
        tick();
        chk("rstw_in_wait_rd", mem_rd, 1);
        chk("rstw_in_wait_addr", mem_addr, 8'h02);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstw_rd_dropped", mem_rd, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("rstw_mem_addr", mem_addr, 8'h00);
        chk("rstw_mem_rd", mem_rd, 0);
        chk("rstw_ir", {IR_Out, IR_Arg}, 8'h00);
        chk("rstw_operand", operand, 8'h00);
        chk("rstw_busy", busy, 0);
        chk("rstw_done", done, 0);
        chk("rstw_y", y, 0);
        chk("rstw_err", err, 0);
        $display("reset mid-WAIT: IR=%h%h op=%02h y=%b err=%b", IR_Out, IR_Arg, operand, y, err);

        last_v = '{2'b01, 1, 0, 0, 0, 8'h00, 8'h4A, 8'h00, 2, 0, 0};
        run_vec(11, last_v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, program memory address width in bits.
REQ-002 Parameter PROG_LAST, default 8'hFF, last valid program address.
REQ-003 Parameter TIMEOUT, default 15, maximum number of cycles spent waiting for mem_ack.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clock  in  1  the only clock; all state updates on posedge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 mcontrol  in  2  fetch command from the microcode sequencer: 00 idle, 01 fetch instruction, 10 fetch operand, 11 jump.
REQ-008 PCD  in  1  PC increment strobe, sampled every cycle.
REQ-009 mem_addr  out  ADDR_W  registered program memory read address.
REQ-010 mem_rd  out  1  memory read request, held until acknowledged or timed out.
REQ-011 mem_rdata  in  8  memory read data, valid when mem_ack=1.
REQ-012 mem_ack  in  1  single-cycle memory acknowledge.
REQ-013 IR_Out  out  4  opcode field, IR[7:4].
REQ-014 IR_Arg  out  4  register field, IR[3:0].
REQ-015 operand  out  8  operand register.
REQ-016 busy  out  1  high in every state other than IDLE.
REQ-017 done  out  1  one-cycle pulse marking command completion.
REQ-018 y  out  1  sticky program-overrun flag.
REQ-019 err  out  1  sticky memory-timeout flag.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, WAIT, DONE and HOLD.
REQ-021 IDLE, mcontrol=01 or 10: SHALL latch the command, load mem_addr<=PC, and go to REQ next cycle.
REQ-022 IDLE, mcontrol=11: SHALL load PC<=operand, go to DONE, and issue no memory access.
REQ-023 REQ: SHALL drive mem_rd=1 for exactly one cycle in this state, then go to WAIT.
REQ-024 WAIT: mem_rd SHALL stay 1; mem_addr SHALL stay stable.
REQ-025 WAIT, mem_ack=1: SHALL load mem_rdata into IR (cmd 01) or operand (cmd 10), drop mem_rd, and go to DONE.
REQ-026 WAIT timeout: after TIMEOUT cycles in WAIT with no ack, SHALL set err=1, drop mem_rd, leave IR and operand unchanged, and go to DONE.
REQ-027 A mem_ack that arrives outside WAIT SHALL be ignored.
REQ-028 DONE: done=1 for one cycle, then go to HOLD.
REQ-029 HOLD: SHALL return to IDLE only when mcontrol=00, so a level-held command executes exactly once.
REQ-030 Fetch latency: with mem_ack in the first WAIT cycle, done SHALL be high 3 cycles after the IDLE command cycle.
REQ-031 PC update: PCD=1 SHALL give PC<=PC+1 (ADDR_W bits) in any state.
REQ-032 PCD wrap: PC wraps to 0 when incremented from all-ones.
REQ-033 PCD at PROG_LAST: PCD=1 with PC==PROG_LAST SHALL set y=1, and PC SHALL still increment.
REQ-034 A jump (mcontrol=11 accepted in IDLE) in the same cycle as PCD=1 SHALL win, giving PC<=operand.
REQ-035 A PCD that arrives during REQ/WAIT SHALL NOT alter the in-flight mem_addr; the next fetch uses the updated PC.
REQ-036 Any mcontrol change outside IDLE/HOLD SHALL be ignored.
REQ-037 y and err SHALL clear only on reset.
REQ-038 IR_Out, IR_Arg and operand SHALL be direct register outputs with no combinational path from inputs.

Reset
REQ-039 Reset SHALL force: state=IDLE, PC=0, mem_addr=0, IR=0, operand=0, mem_rd=0, busy=0, done=0, y=0, err=0, wait counter=0.
REQ-040 Reset asserted mid-fetch SHALL drop mem_rd on the next posedge and discard any late mem_ack.
REQ-041 Reset SHALL take priority over every other input.

Verification
REQ-042 Fetch: reset; memory[0]=8'h4A; mcontrol=01, ack after 2 WAIT cycles -> IR_Out=4, IR_Arg=A, done pulse once, mem_rd high 3 cycles total.
REQ-043 Held command: mcontrol=01 held for 10 cycles -> exactly one mem_rd burst and one done pulse; a second fetch starts only after mcontrol=00 then 01.
REQ-044 Jump: operand=8'h20, mcontrol=11 with PCD=1 in the same cycle -> PC=8'h20, no mem_rd, done pulse.
REQ-045 Overrun: PC=8'hFF, PCD=1 -> y=1, PC=0; y remains 1 through later fetches until reset.
REQ-046 Timeout: mcontrol=10 with no mem_ack -> err=1 after 15 WAIT cycles, operand unchanged, done pulse, mem_rd=0.
REQ-047 Reset mid-WAIT: reset asserted during WAIT, then mem_ack -> all outputs at reset values, IR unchanged at 0.
